if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of instruction decode.
- Owns the PC and issues in-order word requests to instruction memory, which has a variable-latency request/grant/response interface.
- Buffers returned instructions in a small fetch queue and drives the IF/ID pipeline register (IF_ID_pc, IF_ID_inst, IF_ID_vld) consumed by decode.
- Handles decode stalls and EX-stage branch/jump redirects, discarding wrong-path responses still in flight.

---
 rtl/if_fetch_stage.sv | 134 +++++++++++++
 tb/tb_if_fetch_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to imem and feeds the IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/drop/stall performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_stall,
    input  logic        EX_redirect,
    input  logic [31:0] EX_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_vld
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_fetch_cnt,
    output logic [31:0] if_drop_cnt,
    output logic [31:0] if_stall_cnt
`endif
);
    localparam int          CW  = $clog2(FQ_DEPTH + 1);
    localparam int          PW  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding, fq_count, drop_cnt;
    logic [31:0]   pend_pc [FQ_DEPTH];
    logic [PW-1:0] pend_wp, pend_rp;
    logic [31:0]   fq_pc   [FQ_DEPTH];
    logic [31:0]   fq_inst [FQ_DEPTH];
    logic [PW-1:0] fq_wp, fq_rp;

    logic [CW:0] inflight;
    logic        accept, resp, resp_live, id_load, fq_pop, fq_push, bypass;
    logic [31:0] resp_pc;
    logic        unused_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers both queued entries and in-flight requests, so the queue can never overflow.
    assign inflight  = {1'b0, outstanding} + {1'b0, fq_count};
    assign imem_req  = rst && !EX_redirect && (inflight < (CW+1)'(FQ_DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign resp      = imem_rvalid && (outstanding != '0);
    assign resp_live = resp && (drop_cnt == '0) && !EX_redirect;
    assign resp_pc   = pend_pc[pend_rp];
    assign id_load   = !ID_stall && !EX_redirect;
    assign fq_pop    = id_load && (fq_count != '0);
    assign bypass    = id_load && (fq_count == '0) && resp_live;
    assign fq_push   = resp_live && !bypass;
    assign unused_ok = ^EX_target[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fq_count    <= '0;
            pend_wp     <= '0;
            pend_rp     <= '0;
            fq_wp       <= '0;
            fq_rp       <= '0;
            IF_ID_pc    <= '0;
            IF_ID_inst  <= NOP;
            IF_ID_vld   <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (accept) pend_wp <= inc(pend_wp);
            if (resp)   pend_rp <= inc(pend_rp);
            if (EX_redirect) begin
                // Everything not yet returned belongs to the wrong path.
                pc        <= {EX_target[31:2], 2'b00};
                drop_cnt  <= outstanding + CW'(accept) - CW'(resp);
                fq_count  <= '0;
                fq_wp     <= '0;
                fq_rp     <= '0;
                IF_ID_vld <= 1'b0;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                fq_count <= fq_count + CW'(fq_push) - CW'(fq_pop);
                if (fq_push) fq_wp <= inc(fq_wp);
                if (fq_pop)  fq_rp <= inc(fq_rp);
                if (!ID_stall) begin
                    if (fq_pop) begin
                        IF_ID_pc   <= fq_pc[fq_rp];
                        IF_ID_inst <= fq_inst[fq_rp];
                        IF_ID_vld  <= 1'b1;
                    end else if (bypass) begin
                        IF_ID_pc   <= resp_pc;
                        IF_ID_inst <= imem_rdata;
                        IF_ID_vld  <= 1'b1;
                    end else begin
                        IF_ID_vld  <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pend_pc[pend_wp] <= pc;
        if (fq_push) begin
            fq_pc[fq_wp]   <= resp_pc;
            fq_inst[fq_wp] <= imem_rdata;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid && outstanding == '0));

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_fetch_cnt <= '0;
            if_drop_cnt  <= '0;
            if_stall_cnt <= '0;
        end else begin
            if (resp_live && if_fetch_cnt != '1)          if_fetch_cnt <= if_fetch_cnt + 32'd1;
            if (resp && !resp_live && if_drop_cnt != '1)  if_drop_cnt  <= if_drop_cnt + 32'd1;
            if (ID_stall && IF_ID_vld && if_stall_cnt != '1) if_stall_cnt <= if_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + randomized-memory bench for if_fetch_stage with an in-order imem model.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ID_stall, EX_redirect;
    logic [31:0] EX_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        IF_ID_vld;
`ifdef IF_PERF_CNT_EN
    logic [31:0] if_fetch_cnt, if_drop_cnt, if_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    int          mwait;
    bit          hold_resp = 1'b0;
    bit          rand_mode = 1'b0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .ID_stall(ID_stall), .EX_redirect(EX_redirect),
        .EX_target(EX_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_vld(IF_ID_vld)
`ifdef IF_PERF_CNT_EN
        , .if_fetch_cnt(if_fetch_cnt), .if_drop_cnt(if_drop_cnt), .if_stall_cnt(if_stall_cnt)
`endif
    );

    function automatic logic [31:0] minst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // In-order memory: accepted addresses queue up, head returned after mwait idle cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            mwait       <= 0;
        end else begin
            if (imem_req && imem_gnt) mq.push_back(imem_addr);
            if (!hold_resp && mq.size() > 0 && mwait == 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= minst(mq[0]);
                void'(mq.pop_front());
                mwait <= rand_mode ? int'($urandom_range(0, 5)) : 0;
            end else begin
                imem_rvalid <= 1'b0;
                if (mq.size() > 0 && mwait > 0) mwait <= mwait - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        logic [31:0] exp_pc;
        bit prev_stall;
        rst = 1'b0; ID_stall = 1'b0; EX_redirect = 1'b0; EX_target = '0; imem_gnt = 1'b1;
        tick(); tick();
        chk("rst_vld", IF_ID_vld, 0);
        chk("rst_pc", IF_ID_pc, 0);
        chk("rst_inst", IF_ID_inst, 32'h13);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);

        // Zero-wait memory, no stall
        rst = 1'b1; #1;
        chk("first_req", imem_req, 1);
        tick();
        chk("e1_vld", IF_ID_vld, 0);
        chk("e1_addr", imem_addr, 32'h4);
        tick();
        chk("e2_vld", IF_ID_vld, 1);
        chk("e2_pc", IF_ID_pc, 32'h0);
        chk("e2_inst", IF_ID_inst, minst(32'h0));
        tick(); chk("e3_pc", IF_ID_pc, 32'h4);
        tick(); chk("e4_pc", IF_ID_pc, 32'h8); chk("e4_inst", IF_ID_inst, minst(32'h8));

        // Three stall cycles holding 0x8; credit exhausts
        ID_stall = 1'b1;
        tick(); chk("st1_pc", IF_ID_pc, 32'h8); chk("st1_req", imem_req, 0);
        tick(); chk("st2_pc", IF_ID_pc, 32'h8); chk("st2_req", imem_req, 0);
        tick(); chk("st3_pc", IF_ID_pc, 32'h8); chk("st3_vld", IF_ID_vld, 1);
        ID_stall = 1'b0;
        tick(); chk("rel1_pc", IF_ID_pc, 32'hC); chk("rel1_inst", IF_ID_inst, minst(32'hC));
        tick(); chk("rel2_pc", IF_ID_pc, 32'h10); chk("rel2_inst", IF_ID_inst, minst(32'h10));
        tick(); chk("rel3_pc", IF_ID_pc, 32'h14);

        // Build two outstanding requests, then redirect to 0x100
        hold_resp = 1'b1;
        tick(); chk("h1_pc", IF_ID_pc, 32'h18); chk("h1_vld", IF_ID_vld, 1);
        tick(); chk("h2_vld", IF_ID_vld, 0); chk("h2_req", imem_req, 0);
        EX_redirect = 1'b1; EX_target = 32'h100; hold_resp = 1'b0;
        tick(); EX_redirect = 1'b0; #1;
        chk("rd_vld", IF_ID_vld, 0);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_req", imem_req, 0);
        tick(); chk("rd_drop1_vld", IF_ID_vld, 0); chk("rd_drop1_req", imem_req, 1);
        tick(); chk("rd_drop2_vld", IF_ID_vld, 0);
        tick(); chk("rd_new_vld", IF_ID_vld, 1); chk("rd_new_pc", IF_ID_pc, 32'h100);
        chk("rd_new_inst", IF_ID_inst, minst(32'h100));

        // Redirect while a response is arriving; unaligned target
        EX_redirect = 1'b1; EX_target = 32'h203; #1;
        chk("rd2_req_gated", imem_req, 0);
        tick(); EX_redirect = 1'b0; #1;
        chk("rd2_vld", IF_ID_vld, 0);
        chk("rd2_addr", imem_addr, 32'h200);
        tick(); chk("rd2_e1_vld", IF_ID_vld, 0);
        tick(); chk("rd2_pc", IF_ID_pc, 32'h200); chk("rd2_inst", IF_ID_inst, minst(32'h200));
        tick(); chk("rd2_next_pc", IF_ID_pc, 32'h204);

        // Reset mid-stream with two requests outstanding and a valid held in IF/ID
        hold_resp = 1'b1;
        tick(); chk("pre_rst_pc", IF_ID_pc, 32'h208);
        ID_stall = 1'b1;
        tick(); chk("pre_rst_vld", IF_ID_vld, 1); chk("pre_rst_req", imem_req, 0);
        rst = 1'b0; #1;
        chk("arst_vld", IF_ID_vld, 0);
        chk("arst_req", imem_req, 0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_pc", IF_ID_pc, 32'h0);
        chk("arst_inst", IF_ID_inst, 32'h13);
        hold_resp = 1'b0; ID_stall = 1'b0;
        tick();
        rst = 1'b1; #1;
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 32'h0);

        // Random gnt/response delays and random stalls
        rand_mode = 1'b1;
        exp_pc = 32'h0; n = 0; cyc = 0;
        while (n < 1000 && cyc < 40000 && bad < 20) begin
            imem_gnt = ($urandom_range(0, 2) != 0);
            ID_stall = ($urandom_range(0, 3) == 0);
            prev_stall = ID_stall;
            tick();
            cyc++;
            if (!prev_stall && IF_ID_vld) begin
                chk("seq_pc", IF_ID_pc, exp_pc);
                chk("seq_inst", IF_ID_inst, minst(exp_pc));
                exp_pc += 32'd4;
                n++;
            end
        end
        if (bad < 20) chk("seq_count", n, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
